// File: rtl/memory_home_access_ctrl.sv
// Home-node directory controller: reads one line's state+data, applies the coherence
// transition, writes back the new state/data, then answers the requester.
module memory_home_access_ctrl #(
  parameter int DATA_W = 128,
  parameter int ST_W   = 6,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic [1:0]        req_src,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_code,
  output logic [ST_W-1:0]   rsp_state,
  output logic [DATA_W-1:0] rsp_data,
  output logic              state_re_out,
  output logic              data_re_out,
  output logic              state_we_out,
  output logic              data_we_out,
  output logic [31:0]       addr_out,
  output logic [ST_W-1:0]   state_wr_out,
  output logic [DATA_W-1:0] data_wr_out,
  input  logic [ST_W-1:0]   state_rd_in,
  input  logic [DATA_W-1:0] data_rd_in
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] T_RD_SH = 2'b00;
  localparam logic [1:0] T_RD_EX = 2'b01;
  localparam logic [1:0] T_WB    = 2'b10;
  localparam logic [1:0] T_CLR   = 2'b11;

  localparam logic [1:0] CLS_R  = 2'b00;
  localparam logic [1:0] CLS_W  = 2'b01;
  localparam logic [1:0] CLS_TR = 2'b10;
  localparam logic [1:0] CLS_TW = 2'b11;

  localparam logic [2:0] RSP_OK   = 3'b000;
  localparam logic [2:0] RSP_INV  = 3'b001;
  localparam logic [2:0] RSP_FWD  = 3'b010;
  localparam logic [2:0] RSP_NACK = 3'b011;
  localparam logic [2:0] RSP_ERR  = 3'b100;

  logic [2:0]      fsm;
  logic [1:0]      lat_type;
  logic [1:0]      lat_src;
  logic            state_we_q;
  logic            data_we_q;

  logic [1:0]      cls;
  logic [3:0]      dir;
  logic [1:0]      owner;
  logic [3:0]      src_bit;
  logic [3:0]      owner_bit;
  logic [ST_W-1:0] ev_state;
  logic [2:0]      ev_code;
  logic            ev_swe;
  logic            ev_dwe;

  assign cls       = state_rd_in[5:4];
  assign dir       = state_rd_in[3:0];
  assign owner     = state_rd_in[1:0];
  assign src_bit   = 4'b0001 << lat_src;
  assign owner_bit = 4'b0001 << owner;

  // Directory transition, evaluated on the RAM read data during EVAL.
  always_comb begin
    ev_state = state_rd_in;
    ev_code  = RSP_ERR;
    ev_swe   = 1'b0;
    ev_dwe   = 1'b0;
    case (cls)
      CLS_R: begin
        if (lat_type == T_RD_SH) begin
          ev_state = {CLS_R, dir | src_bit};
          ev_code  = RSP_OK;
          ev_swe   = 1'b1;
        end else if (lat_type == T_RD_EX) begin
          ev_swe = 1'b1;
          if ((dir & ~src_bit) == 4'b0000) begin
            ev_state = {CLS_W, 2'b00, lat_src};
            ev_code  = RSP_OK;
          end else begin
            ev_state = {CLS_TW, 2'b00, lat_src};
            ev_code  = RSP_INV;
          end
        end
      end
      CLS_W: begin
        if (lat_type == T_RD_SH) begin
          ev_state = {CLS_TR, owner_bit | src_bit};
          ev_code  = RSP_FWD;
          ev_swe   = 1'b1;
        end else if (lat_type == T_RD_EX) begin
          ev_state = {CLS_TW, 2'b00, lat_src};
          ev_code  = RSP_FWD;
          ev_swe   = 1'b1;
        end else if (lat_type == T_WB && owner == lat_src) begin
          ev_state = {CLS_R, 4'b0000};
          ev_code  = RSP_OK;
          ev_swe   = 1'b1;
          ev_dwe   = 1'b1;
        end
      end
      CLS_TR: begin
        if (lat_type == T_RD_SH || lat_type == T_RD_EX) begin
          ev_code = RSP_NACK;
        end else if (lat_type == T_WB) begin
          ev_state = {CLS_R, dir};
          ev_code  = RSP_OK;
          ev_swe   = 1'b1;
          ev_dwe   = 1'b1;
        end
      end
      default: begin
        if (lat_type == T_RD_SH || lat_type == T_RD_EX) begin
          ev_code = RSP_NACK;
        end else begin
          // WB and CLR both retire the pending exclusive grant; only WB carries data.
          ev_state = {CLS_W, 2'b00, owner};
          ev_code  = RSP_OK;
          ev_swe   = 1'b1;
          ev_dwe   = (lat_type == T_WB);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= S_IDLE;
      lat_type     <= 2'b00;
      lat_src      <= 2'b00;
      addr_out     <= 32'h0;
      data_wr_out  <= '0;
      rsp_code     <= 3'b000;
      rsp_state    <= '0;
      rsp_data     <= '0;
      state_wr_out <= '0;
      state_we_q   <= 1'b0;
      data_we_q    <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (req_valid) begin
            lat_type    <= req_type;
            lat_src     <= req_src;
            addr_out    <= {req_addr[31:IDX_W+4], req_addr[IDX_W+3:4], req_addr[3:0]};
            data_wr_out <= req_data;
            fsm         <= S_READ;
          end
        end
        S_READ: fsm <= S_EVAL;
        S_EVAL: begin
          rsp_state    <= state_rd_in;
          rsp_data     <= data_rd_in;
          rsp_code     <= ev_code;
          state_wr_out <= ev_state;
          state_we_q   <= ev_swe;
          data_we_q    <= ev_dwe;
          fsm          <= S_WRITE;
        end
        S_WRITE: fsm <= S_RESP;
        S_RESP: begin
          if (rsp_ready) begin
            fsm <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the FSM so an async reset kills them immediately.
  assign req_ready    = (fsm == S_IDLE);
  assign rsp_valid    = (fsm == S_RESP);
  assign state_re_out = (fsm == S_READ);
  assign data_re_out  = (fsm == S_READ);
  assign state_we_out = (fsm == S_WRITE) && state_we_q;
  assign data_we_out  = (fsm == S_WRITE) && data_we_q;

endmodule

// File: tb/tb_memory_home_access_ctrl.sv
// Bench for memory_home_access_ctrl: behavioural RAM, a rule-level directory model
// and a per-cycle compare process, plus directed transactions with literal expectations.
module tb_memory_home_access_ctrl;

  localparam int DATA_W = 128;

  localparam logic [1:0] RD_SH = 2'b00;
  localparam logic [1:0] RD_EX = 2'b01;
  localparam logic [1:0] WB    = 2'b10;
  localparam logic [1:0] CLR   = 2'b11;

  localparam logic [2:0] C_OK   = 3'b000;
  localparam logic [2:0] C_INV  = 3'b001;
  localparam logic [2:0] C_FWD  = 3'b010;
  localparam logic [2:0] C_NACK = 3'b011;
  localparam logic [2:0] C_ERR  = 3'b100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_type = 2'b00;
  logic [1:0]        req_src = 2'b00;
  logic [31:0]       req_addr = 32'h0;
  logic [DATA_W-1:0] req_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [2:0]        rsp_code;
  logic [5:0]        rsp_state;
  logic [DATA_W-1:0] rsp_data;
  logic              state_re_out, data_re_out, state_we_out, data_we_out;
  logic [31:0]       addr_out;
  logic [5:0]        state_wr_out;
  logic [DATA_W-1:0] data_wr_out;
  logic [5:0]        state_rd_in = 6'h0;
  logic [DATA_W-1:0] data_rd_in = '0;

  int errors = 0;
  int checks = 0;
  logic run_checks = 1'b0;

  always #5 clk = ~clk;

  memory_home_access_ctrl #(.DATA_W(DATA_W), .ST_W(6), .IDX_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_src(req_src),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
    .rsp_state(rsp_state), .rsp_data(rsp_data),
    .state_re_out(state_re_out), .data_re_out(data_re_out),
    .state_we_out(state_we_out), .data_we_out(data_we_out),
    .addr_out(addr_out), .state_wr_out(state_wr_out), .data_wr_out(data_wr_out),
    .state_rd_in(state_rd_in), .data_rd_in(data_rd_in)
  );

  // Preload port shared by the RAM and the model so both start from the same contents.
  logic              pl_en = 1'b0;
  logic [6:0]        pl_idx = 7'd0;
  logic [5:0]        pl_st = 6'd0;
  logic [DATA_W-1:0] pl_d = '0;

  logic [5:0]        ram_st [128];
  logic [DATA_W-1:0] ram_d  [128];

  always @(posedge clk) begin
    if (state_re_out) state_rd_in <= ram_st[addr_out[10:4]];
    if (data_re_out)  data_rd_in  <= ram_d[addr_out[10:4]];
    if (state_we_out) ram_st[addr_out[10:4]] <= state_wr_out;
    if (data_we_out)  ram_d[addr_out[10:4]]  <= data_wr_out;
    if (pl_en) begin
      ram_st[pl_idx] <= pl_st;
      ram_d[pl_idx]  <= pl_d;
    end
  end

  // Directory rules restated from the protocol description.
  function automatic void model_eval(input logic [5:0] st, input logic [1:0] typ, input logic [1:0] src,
                                     output logic [2:0] code, output logic [5:0] nst,
                                     output logic swe, output logic dwe);
    logic [3:0] me;
    logic       transient;
    logic       owned;
    me        = 4'b0001 << src;
    transient = st[5];
    owned     = st[4];
    nst  = st;
    swe  = 1'b0;
    dwe  = 1'b0;
    code = C_ERR;
    if (typ == CLR) begin
      if (transient && owned) begin
        nst = {4'b0100, st[1:0]}; code = C_OK; swe = 1'b1;
      end
    end else if (typ == WB) begin
      if (transient) begin
        nst  = owned ? {4'b0100, st[1:0]} : {2'b00, st[3:0]};
        code = C_OK; swe = 1'b1; dwe = 1'b1;
      end else if (owned && st[1:0] == src) begin
        nst = 6'b000000; code = C_OK; swe = 1'b1; dwe = 1'b1;
      end
    end else if (transient) begin
      code = C_NACK;
    end else if (owned) begin
      code = C_FWD; swe = 1'b1;
      nst  = (typ == RD_SH) ? {2'b10, ((4'b0001 << st[1:0]) | me)} : {4'b1100, src};
    end else if (typ == RD_SH) begin
      nst = {2'b00, st[3:0] | me}; code = C_OK; swe = 1'b1;
    end else begin
      swe = 1'b1;
      if ((st[3:0] & ~me) != 4'b0000) begin
        nst = {4'b1100, src}; code = C_INV;
      end else begin
        nst = {4'b0100, src}; code = C_OK;
      end
    end
  endfunction

  logic [5:0]        m_st [128];
  logic [DATA_W-1:0] m_d  [128];
  logic [2:0]        nx_code;
  logic [5:0]        nx_new;
  logic              nx_swe, nx_dwe;

  always_comb begin
    model_eval(m_st[req_addr[10:4]], req_type, req_src, nx_code, nx_new, nx_swe, nx_dwe);
  end

  // Protocol phase of the in-flight request: 0 idle, 1 read, 2 eval, 3 write, 4 respond.
  int                phase = 0;
  int                cyc = 0;
  int                acc_cyc = 0;
  logic [31:0]       cur_addr = 32'h0;
  logic [DATA_W-1:0] cur_data = '0;
  logic [2:0]        exp_code = 3'b000;
  logic [5:0]        exp_new = 6'h0;
  logic [5:0]        exp_old = 6'h0;
  logic [DATA_W-1:0] exp_old_d = '0;
  logic              exp_swe = 1'b0;
  logic              exp_dwe = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
    end else begin
      cyc <= cyc + 1;
      if (pl_en) begin
        m_st[pl_idx] <= pl_st;
        m_d[pl_idx]  <= pl_d;
      end
      case (phase)
        0: if (req_valid) begin
             cur_addr  <= req_addr;
             cur_data  <= req_data;
             exp_code  <= nx_code;
             exp_new   <= nx_new;
             exp_swe   <= nx_swe;
             exp_dwe   <= nx_dwe;
             exp_old   <= m_st[req_addr[10:4]];
             exp_old_d <= m_d[req_addr[10:4]];
             acc_cyc   <= cyc;
             phase     <= 1;
           end
        3: begin
             if (exp_swe) m_st[cur_addr[10:4]] <= exp_new;
             if (exp_dwe) m_d[cur_addr[10:4]]  <= cur_data;
             phase <= 4;
           end
        4: if (rsp_ready) phase <= 0;
        default: phase <= phase + 1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && run_checks) begin
      checkOutput("req_ready", req_ready, phase == 0);
      checkOutput("state_re", state_re_out, phase == 1);
      checkOutput("data_re", data_re_out, phase == 1);
      checkOutput("state_we", state_we_out, phase == 3 && exp_swe);
      checkOutput("data_we", data_we_out, phase == 3 && exp_dwe);
      checkOutput("rsp_valid", rsp_valid, phase == 4);
      if (phase != 0) checkOutput("addr_out", addr_out, cur_addr);
      if (phase == 3 && exp_swe) checkOutput("state_wr", state_wr_out, exp_new);
      if (phase == 3 && exp_dwe) checkOutput("data_wr", data_wr_out, cur_data);
      if (phase == 4) begin
        checkOutput("rsp_code", rsp_code, exp_code);
        checkOutput("rsp_state", rsp_state, exp_old);
        checkOutput("rsp_data", rsp_data, exp_old_d);
      end
    end
  end

  task automatic preload(input int idx, input logic [5:0] st, input logic [DATA_W-1:0] d);
    pl_idx = 7'(idx);
    pl_st  = st;
    pl_d   = d;
    pl_en  = 1'b1;
    @(posedge clk);
    #2 pl_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] typ, input logic [1:0] src,
                               input logic [31:0] addr, input logic [DATA_W-1:0] data);
    int n;
    n = 0;
    req_type  = typ;
    req_src   = src;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    while (phase != 1 && n < 20) begin
      @(posedge clk);
      #1 n = n + 1;
    end
    req_valid = 1'b0;
    checkOutput("accept_wait", phase == 1, 1'b1);
  endtask

  task automatic finishReq(input int hold, input logic pre, input logic [1:0] ptype, input logic [1:0] psrc,
                           input logic [31:0] paddr, input logic [DATA_W-1:0] pdata,
                           output logic [2:0] code, output logic [5:0] st,
                           output logic [DATA_W-1:0] d, output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!rsp_valid && n < 20);
    checkOutput("rsp_wait", rsp_valid, 1'b1);
    code = rsp_code;
    st   = rsp_state;
    d    = rsp_data;
    lat  = cyc - acc_cyc;
    if (pre) begin
      req_type  = ptype;
      req_src   = psrc;
      req_addr  = paddr;
      req_data  = pdata;
      req_valid = 1'b1;
    end
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic runTxn(input string tag, input logic [1:0] typ, input logic [1:0] src,
                        input logic [31:0] addr, input logic [DATA_W-1:0] data,
                        input logic [2:0] lit_code, input logic [5:0] lit_old,
                        input logic lit_swe, input logic [5:0] lit_new, input logic lit_dwe);
    logic [2:0]        code;
    logic [5:0]        st;
    logic [DATA_W-1:0] d;
    int                lat;
    applyStimulus(typ, src, addr, data);
    finishReq(0, 1'b0, 2'b00, 2'b00, 32'h0, '0, code, st, d, lat);
    checkOutput({tag, "_code"}, code, lit_code);
    checkOutput({tag, "_rsp_state"}, st, lit_old);
    checkOutput({tag, "_latency"}, lat, 4);
    checkOutput({tag, "_model_swe"}, exp_swe, lit_swe);
    checkOutput({tag, "_model_dwe"}, exp_dwe, lit_dwe);
    if (lit_swe) checkOutput({tag, "_model_new"}, exp_new, lit_new);
  endtask

  localparam logic [DATA_W-1:0] D5  = {4{32'h5555_0005}};
  localparam logic [DATA_W-1:0] D9  = {4{32'h9999_0009}};
  localparam logic [DATA_W-1:0] D20 = {4{32'h2020_0014}};
  localparam logic [DATA_W-1:0] DA5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] DX  = {4{32'hC0DE_1111}};
  localparam logic [DATA_W-1:0] DY  = {4{32'hBEEF_2222}};

  initial begin
    logic [2:0]        code;
    logic [5:0]        st;
    logic [DATA_W-1:0] d;
    int                lat;
    int                n;
    int                idx_list [5];

    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_re", {state_re_out, data_re_out}, 2'b00);
    checkOutput("rst_we", {state_we_out, data_we_out}, 2'b00);
    checkOutput("rst_rsp_code", rsp_code, 3'b000);
    checkOutput("rst_rsp_state", rsp_state, 6'h0);
    checkOutput("rst_rsp_data", rsp_data, 128'h0);
    checkOutput("rst_addr_out", addr_out, 32'h0);
    checkOutput("rst_state_wr", state_wr_out, 6'h0);
    checkOutput("rst_data_wr", data_wr_out, 128'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_checks = 1'b1;

    preload(5, 6'b000000, D5);
    runTxn("r_rdsh", RD_SH, 2'd2, 32'h0000_0050, '0, C_OK, 6'b000000, 1'b1, 6'b000100, 1'b0);
    preload(5, 6'b000110, D5);
    runTxn("r_rdex_inv", RD_EX, 2'd1, 32'h0000_005C, '0, C_INV, 6'b000110, 1'b1, 6'b110001, 1'b0);
    preload(9, 6'b010011, D9);
    runTxn("w_wb_own", WB, 2'd3, 32'h1234_0094, DA5, C_OK, 6'b010011, 1'b1, 6'b000000, 1'b1);
    preload(9, 6'b010011, D9);
    runTxn("w_wb_other", WB, 2'd0, 32'h1234_0094, DA5, C_ERR, 6'b010011, 1'b0, 6'b000000, 1'b0);
    preload(9, 6'b110010, D9);
    runTxn("tw_rdsh", RD_SH, 2'd0, 32'h0000_0090, '0, C_NACK, 6'b110010, 1'b0, 6'b000000, 1'b0);
    runTxn("tw_clr", CLR, 2'd2, 32'h0000_0090, '0, C_OK, 6'b110010, 1'b1, 6'b010010, 1'b0);

    // Response held off for 5 cycles with the next request already waiting.
    preload(20, 6'b010010, D20);
    applyStimulus(RD_SH, 2'd0, 32'h0000_0140, '0);
    finishReq(5, 1'b1, RD_EX, 2'd3, 32'h0000_0140, '0, code, st, d, lat);
    checkOutput("hold_code", code, C_FWD);
    checkOutput("hold_rsp_state", st, 6'b010010);
    checkOutput("hold_rsp_data", d, D20);
    checkOutput("hold_model_new", exp_new, 6'b100101);
    applyStimulus(RD_EX, 2'd3, 32'h0000_0140, '0);
    finishReq(0, 1'b0, 2'b00, 2'b00, 32'h0, '0, code, st, d, lat);
    checkOutput("b2b_code", code, C_NACK);
    checkOutput("b2b_rsp_state", st, 6'b100101);

    runTxn("tr_wb", WB, 2'd1, 32'h0000_0140, DX, C_OK, 6'b100101, 1'b1, 6'b000101, 1'b1);
    runTxn("r_wb", WB, 2'd1, 32'h0000_0140, DY, C_ERR, 6'b000101, 1'b0, 6'b000000, 1'b0);
    runTxn("r_clr", CLR, 2'd1, 32'h0000_0140, '0, C_ERR, 6'b000101, 1'b0, 6'b000000, 1'b0);
    runTxn("r_rdex_inv2", RD_EX, 2'd0, 32'h0000_0140, '0, C_INV, 6'b000101, 1'b1, 6'b110000, 1'b0);
    runTxn("tw_wb", WB, 2'd2, 32'h0000_0140, DY, C_OK, 6'b110000, 1'b1, 6'b010000, 1'b1);
    runTxn("w_rdex", RD_EX, 2'd3, 32'h0000_0140, '0, C_FWD, 6'b010000, 1'b1, 6'b110011, 1'b0);
    runTxn("tw_clr2", CLR, 2'd0, 32'h0000_0140, '0, C_OK, 6'b110011, 1'b1, 6'b010011, 1'b0);
    runTxn("w_clr", CLR, 2'd0, 32'h0000_0140, '0, C_ERR, 6'b010011, 1'b0, 6'b000000, 1'b0);
    preload(30, 6'b100011, D20);
    runTxn("tr_clr", CLR, 2'd1, 32'h0000_01E0, '0, C_ERR, 6'b100011, 1'b0, 6'b000000, 1'b0);
    runTxn("tr_rdex", RD_EX, 2'd1, 32'h0000_01E0, '0, C_NACK, 6'b100011, 1'b0, 6'b000000, 1'b0);
    preload(30, 6'b000010, D20);
    runTxn("r_rdex_sole", RD_EX, 2'd1, 32'h0000_01E0, '0, C_OK, 6'b000010, 1'b1, 6'b010001, 1'b0);

    // Reset pulled while the write strobe is up: the write must never land.
    preload(64, 6'b000000, D5);
    applyStimulus(RD_SH, 2'd3, 32'h0000_0400, '0);
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (phase != 3 && n < 10);
    checkOutput("reach_write", phase, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_state_we", state_we_out, 1'b0);
    checkOutput("rstmid_data_we", data_we_out, 1'b0);
    checkOutput("rstmid_req_ready", req_ready, 1'b1);
    checkOutput("rstmid_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    runTxn("post_rst", RD_SH, 2'd3, 32'h0000_0400, '0, C_OK, 6'b000000, 1'b1, 6'b001000, 1'b0);

    repeat (2) @(posedge clk);
    idx_list = '{5, 9, 20, 30, 64};
    foreach (idx_list[i]) begin
      checkOutput($sformatf("mem_st_%0d", idx_list[i]), ram_st[idx_list[i]], m_st[idx_list[i]]);
      checkOutput($sformatf("mem_d_%0d", idx_list[i]), ram_d[idx_list[i]], m_d[idx_list[i]]);
    end
    checkOutput("mem_st9_lit", ram_st[9], 6'b010010);
    checkOutput("mem_st20_lit", ram_st[20], 6'b010011);
    checkOutput("mem_d20_lit", ram_d[20], DY);
    checkOutput("mem_st64_lit", ram_st[64], 6'b001000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
